// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory bus plus the fetch/decode pipeline signals.
interface instr_fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_readdata;
    logic        imem_busywait;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        if_valid;
    modport master (
        output imem_addr, imem_read, instruction, pc_out, if_valid,
        input  imem_readdata, imem_busywait, branch_taken, branch_target, stall
    );
    modport slave (
        input  imem_addr, imem_read, instruction, pc_out, if_valid,
        output imem_readdata, imem_busywait, branch_taken, branch_target, stall
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencing and IF/ID register with busy-wait, stall buffering and redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
    input logic clk,
    input logic rst_n,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t      state;
    logic [31:0] pc, old_addr, hold_word, hold_pc, instruction, pc_out;
    logic        if_valid, busy;
    assign busy            = bus.imem_busywait;
    assign bus.imem_read   = rst_n && state != HOLD;
    assign bus.imem_addr   = state == DISCARD ? old_addr : pc;
    assign bus.instruction = instruction;
    assign bus.pc_out      = pc_out;
    assign bus.if_valid    = if_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_VECTOR;
            old_addr    <= RESET_VECTOR;
            hold_word   <= NOP_WORD;
            hold_pc     <= RESET_VECTOR;
            instruction <= NOP_WORD;
            pc_out      <= RESET_VECTOR;
            if_valid    <= 1'b0;
        end else if (bus.branch_taken) begin
            pc          <= {bus.branch_target[31:2], 2'b00};
            instruction <= NOP_WORD;
            if_valid    <= 1'b0;
            hold_word   <= NOP_WORD;
            // An outstanding busy read must finish on its own address before the target is issued
            if (state == FETCH && busy) begin
                state    <= DISCARD;
                old_addr <= pc;
            end else if (!(state == DISCARD && busy)) begin
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (bus.stall) begin
                        if (!busy) begin
                            hold_word <= bus.imem_readdata;
                            hold_pc   <= pc;
                            pc        <= pc + 32'd4;
                            state     <= HOLD;
                        end
                    end else if (!busy) begin
                        instruction <= bus.imem_readdata;
                        pc_out      <= pc;
                        if_valid    <= 1'b1;
                        pc          <= pc + 32'd4;
                    end else begin
                        instruction <= NOP_WORD;
                        if_valid    <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        instruction <= hold_word;
                        pc_out      <= hold_pc;
                        if_valid    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                DISCARD: state <= busy ? DISCARD : FETCH;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table, reset sequence and randomized program-order model check.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    instr_fetch_unit_if bus();
    instr_fetch_unit #(.RESET_VECTOR(32'h0), .NOP_WORD(NOP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction
    assign bus.imem_readdata = memw(bus.imem_addr);

    typedef struct {
        logic        busy, stall, br;
        logic [31:0] tgt;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc, exp_instr;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic busy, stall, br, input logic [31:0] tgt,
                                input logic rd, input logic [31:0] addr,
                                input logic valid, input logic [31:0] pc);
        vec_t v;
        v.busy = busy; v.stall = stall; v.br = br; v.tgt = tgt;
        v.exp_read = rd; v.exp_addr = addr; v.exp_valid = valid; v.exp_pc = pc;
        v.exp_instr = valid ? memw(pc) : NOP;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic        pend;
    logic [31:0] pend_addr, exp_next, p_instr, p_pc, tgt;
    logic        p_valid, br, stl;
    int          delivered;

    initial begin
        bus.imem_busywait = 0; bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
        // busy stall br tgt | read addr | valid pc_out
        add(0,0,0,0, 1,32'h00, 1,32'h00);
        add(0,0,0,0, 1,32'h04, 1,32'h04);
        add(0,0,0,0, 1,32'h08, 1,32'h08);
        add(0,0,0,0, 1,32'h0C, 1,32'h0C);
        add(1,0,0,0, 1,32'h10, 0,32'h0C);
        add(1,0,0,0, 1,32'h10, 0,32'h0C);
        add(1,0,0,0, 1,32'h10, 0,32'h0C);
        add(0,0,0,0, 1,32'h10, 1,32'h10);
        add(0,1,0,0, 1,32'h14, 1,32'h10);
        add(0,1,0,0, 0,32'h00, 1,32'h10);
        add(0,0,0,0, 0,32'h00, 1,32'h14);
        add(0,0,0,0, 1,32'h18, 1,32'h18);
        add(0,0,1,32'h43, 1,32'h1C, 0,32'h18);
        add(0,0,0,0, 1,32'h40, 1,32'h40);
        add(1,0,1,32'h80, 1,32'h44, 0,32'h40);
        add(1,0,0,0, 1,32'h44, 0,32'h40);
        add(0,0,0,0, 1,32'h44, 0,32'h40);
        add(0,0,0,0, 1,32'h80, 1,32'h80);
        repeat (2) @(negedge clk);
        chk("rst_instr", bus.instruction, NOP);
        chk("rst_valid", {31'b0, bus.if_valid}, 0);
        chk("rst_pc_out", bus.pc_out, 0);
        chk("rst_read", {31'b0, bus.imem_read}, 0);
        rst_n = 1;
        foreach (tbl[i]) begin
            bus.imem_busywait = tbl[i].busy; bus.stall = tbl[i].stall;
            bus.branch_taken = tbl[i].br; bus.branch_target = tbl[i].tgt;
            #1;
            chk($sformatf("v%0d_read", i), {31'b0, bus.imem_read}, {31'b0, tbl[i].exp_read});
            if (tbl[i].exp_read) chk($sformatf("v%0d_addr", i), bus.imem_addr, tbl[i].exp_addr);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'b0, bus.if_valid}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("v%0d_pc_out", i), bus.pc_out, tbl[i].exp_pc);
            chk($sformatf("v%0d_instr", i), bus.instruction, tbl[i].exp_instr);
            @(negedge clk);
        end
        bus.imem_busywait = 1; bus.stall = 0; bus.branch_taken = 0;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("async_rst_instr", bus.instruction, NOP);
        chk("async_rst_valid", {31'b0, bus.if_valid}, 0);
        chk("async_rst_pc_out", bus.pc_out, 0);
        chk("async_rst_read", {31'b0, bus.imem_read}, 0);
        @(negedge clk);
        rst_n = 1; bus.imem_busywait = 0;
        #1;
        chk("post_rst_addr", bus.imem_addr, 0);
        chk("post_rst_read", {31'b0, bus.imem_read}, 1);
        @(posedge clk); #1;
        chk("post_rst_pc", bus.pc_out, 0);
        chk("post_rst_instr", bus.instruction, memw(0));
        // Program-order model: each delivered word follows the previous one or the latest redirect
        exp_next = 4; pend = 0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (pend) begin
                chk("busy_read_held", {31'b0, bus.imem_read}, 1);
                chk("busy_addr_held", bus.imem_addr, pend_addr);
            end
            bus.imem_busywait = $urandom_range(0, 9) < 3;
            stl = $urandom_range(0, 3) == 0;
            br = $urandom_range(0, 15) == 0;
            tgt = $urandom;
            bus.stall = stl; bus.branch_taken = br; bus.branch_target = tgt;
            pend = bus.imem_read && bus.imem_busywait;
            pend_addr = bus.imem_addr;
            p_instr = bus.instruction; p_pc = bus.pc_out; p_valid = bus.if_valid;
            @(posedge clk); #1;
            if (br) begin
                chk("br_valid", {31'b0, bus.if_valid}, 0);
                chk("br_instr", bus.instruction, NOP);
                exp_next = {tgt[31:2], 2'b00};
            end else if (stl) begin
                chk("stall_instr", bus.instruction, p_instr);
                chk("stall_pc", bus.pc_out, p_pc);
                chk("stall_valid", {31'b0, bus.if_valid}, {31'b0, p_valid});
            end else if (bus.if_valid) begin
                chk("seq_pc", bus.pc_out, exp_next);
                chk("seq_instr", bus.instruction, memw(exp_next));
                exp_next += 4;
                delivered++;
            end else begin
                chk("bubble_instr", bus.instruction, NOP);
            end
        end
        chk("progress", {31'b0, delivered > 300}, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
